// File: rtl/stage_sequencer.sv
// Multi-cycle MIPS control sequencer: steps FETCH..WRITEBACK and decodes the latched
// opcode into ALU controls and datapath strobes. Every output is a registered flop.
module stage_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   input  logic             mem_ready,
   input  logic             zero,
   output logic             instr_ack,
   output logic [2:0]       stage,
   output logic [1:0]       alu_op,
   output logic [5:0]       alu_funct,
   output logic             alu_src,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             branch_taken,
   output logic             illegal,
   output logic             mem_error,
   output logic [CNT_W-1:0] retired
);

   // state        | meaning
   // ST_FETCH     | idle, waiting for instr_valid
   // ST_DECODE    | opcode classified, illegal ones abort here
   // ST_EXECUTE   | single ALU cycle
   // ST_MEMORY    | lw/sw access with timeout, or beq resolution
   // ST_WRITEBACK | one-cycle register-file write
   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4
   } stage_t;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   stage_t            stage_q, stage_d;
   logic [31:0]       instr_q, instr_d;
   logic              instr_ack_q, instr_ack_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic [5:0]        alu_funct_q, alu_funct_d;
   logic              alu_src_q, alu_src_d;
   logic              reg_dst_q, reg_dst_d;
   logic              reg_write_q, reg_write_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              branch_taken_q, branch_taken_d;
   logic              illegal_q, illegal_d;
   logic              mem_error_q, mem_error_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic [5:0]        opcode;
   logic              is_rtype, is_addi, is_lw, is_sw, is_beq;
   logic [WAIT_W-1:0] wait_inc;
   logic              go_idle;

   always_comb begin
      opcode   = instr_q[31:26];
      is_rtype = (opcode == OP_RTYPE);
      is_addi  = (opcode == OP_ADDI);
      is_lw    = (opcode == OP_LW);
      is_sw    = (opcode == OP_SW);
      is_beq   = (opcode == OP_BEQ);
      wait_inc = wait_cnt_q + WAIT_W'(1);

      stage_d        = stage_q;
      instr_d        = instr_q;
      alu_op_d       = alu_op_q;
      alu_funct_d    = alu_funct_q;
      alu_src_d      = alu_src_q;
      reg_dst_d      = reg_dst_q;
      mem_read_d     = mem_read_q;
      mem_write_d    = mem_write_q;
      mem_to_reg_d   = mem_to_reg_q;
      retired_d      = retired_q;
      wait_cnt_d     = wait_cnt_q;
      instr_ack_d    = 1'b0;
      reg_write_d    = 1'b0;
      branch_taken_d = 1'b0;
      illegal_d      = 1'b0;
      mem_error_d    = 1'b0;
      go_idle        = 1'b0;

      case (stage_q)
         ST_FETCH: begin
            if (instr_valid) begin
               instr_d     = instr;
               instr_ack_d = 1'b1;
               stage_d     = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_rtype || is_addi || is_lw || is_sw || is_beq) begin
               stage_d      = ST_EXECUTE;
               alu_funct_d  = instr_q[5:0];
               alu_op_d     = is_rtype ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
               alu_src_d    = is_addi || is_lw || is_sw;
               reg_dst_d    = is_rtype;
               mem_to_reg_d = is_lw;
            end else begin
               illegal_d = 1'b1;
               go_idle   = 1'b1;
            end
         end
         ST_EXECUTE: begin
            wait_cnt_d = '0;
            if (is_rtype || is_addi) begin
               stage_d     = ST_WRITEBACK;
               reg_write_d = 1'b1;
            end else begin
               stage_d     = ST_MEMORY;
               mem_read_d  = is_lw;
               mem_write_d = is_sw;
            end
         end
         ST_MEMORY: begin
            if (is_beq) begin
               branch_taken_d = zero;
               retired_d      = retired_q + CNT_W'(1);
               go_idle        = 1'b1;
            end else if (mem_ready) begin
               // completion takes priority over a timeout landing on the same cycle
               if (is_lw) begin
                  stage_d     = ST_WRITEBACK;
                  mem_read_d  = 1'b0;
                  reg_write_d = 1'b1;
               end else begin
                  retired_d = retired_q + CNT_W'(1);
                  go_idle   = 1'b1;
               end
            end else if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
               mem_error_d = 1'b1;
               go_idle     = 1'b1;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         ST_WRITEBACK: begin
            retired_d = retired_q + CNT_W'(1);
            go_idle   = 1'b1;
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (go_idle) begin
         stage_d      = ST_FETCH;
         alu_op_d     = 2'b00;
         alu_funct_d  = 6'd0;
         alu_src_d    = 1'b0;
         reg_dst_d    = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         wait_cnt_d   = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_q        <= ST_FETCH;
         instr_q        <= 32'd0;
         instr_ack_q    <= 1'b0;
         alu_op_q       <= 2'b00;
         alu_funct_q    <= 6'd0;
         alu_src_q      <= 1'b0;
         reg_dst_q      <= 1'b0;
         reg_write_q    <= 1'b0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_to_reg_q   <= 1'b0;
         branch_taken_q <= 1'b0;
         illegal_q      <= 1'b0;
         mem_error_q    <= 1'b0;
         retired_q      <= '0;
         wait_cnt_q     <= '0;
      end else begin
         stage_q        <= stage_d;
         instr_q        <= instr_d;
         instr_ack_q    <= instr_ack_d;
         alu_op_q       <= alu_op_d;
         alu_funct_q    <= alu_funct_d;
         alu_src_q      <= alu_src_d;
         reg_dst_q      <= reg_dst_d;
         reg_write_q    <= reg_write_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
         mem_to_reg_q   <= mem_to_reg_d;
         branch_taken_q <= branch_taken_d;
         illegal_q      <= illegal_d;
         mem_error_q    <= mem_error_d;
         retired_q      <= retired_d;
         wait_cnt_q     <= wait_cnt_d;
      end
   end

   assign stage        = stage_q;
   assign instr_ack    = instr_ack_q;
   assign alu_op       = alu_op_q;
   assign alu_funct    = alu_funct_q;
   assign alu_src      = alu_src_q;
   assign reg_dst      = reg_dst_q;
   assign reg_write    = reg_write_q;
   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_to_reg   = mem_to_reg_q;
   assign branch_taken = branch_taken_q;
   assign illegal      = illegal_q;
   assign mem_error    = mem_error_q;
   assign retired      = retired_q;

endmodule
